// File: rtl/welch_window_segmenter_if.sv
// AXI-Stream style link carrying two packed complex 16-bit samples per beat.
// Used both for the preprocessed input stream and the windowed output stream.
interface welch_window_segmenter_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/welch_window_segmenter.sv
// Cuts the complex sample stream into 50%-overlapped segments, applies a runtime-loaded
// Q1.15 window and emits each windowed segment as one packet for the FFT.
module welch_window_segmenter #(
  parameter int SEG_LEN = 1024,
  parameter int COEF_W  = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  welch_window_segmenter_if.slave    s_axis,
  welch_window_segmenter_if.master   m_axis,
  input  logic                       coef_wr_en,
  input  logic [$clog2(SEG_LEN)-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]          coef_wr_data,
  output logic [31:0]                seg_count,
  output logic                       busy
);
  localparam int BEATS = SEG_LEN / 2;
  localparam int QTR   = SEG_LEN / 4;
  localparam int AW    = $clog2(SEG_LEN);
  localparam int BW    = $clog2(BEATS);
  localparam int PW    = 16 + COEF_W;
  localparam int SH    = COEF_W - 1;
  localparam logic signed [PW:0] RND    = (PW+1)'(2 ** (SH - 1));
  localparam logic signed [PW:0] SAT_HI = (PW+1)'(32767);
  localparam logic signed [PW:0] SAT_LO = (PW+1)'(-32768);

  typedef enum logic [1:0] {FILL_FIRST, FILL_HALF, EMIT} state_t;

  state_t state, state_nxt;

  logic [63:0]              sample_mem [BEATS];
  logic signed [COEF_W-1:0] coef_even  [BEATS];
  logic signed [COEF_W-1:0] coef_odd   [BEATS];

  logic [BW-1:0] wp, rd_cnt, fill_cnt;
  logic          s_ready, accept, restart, fill_done;
  logic          issue, last_issue;
  logic          adv1, adv2, adv3;

  logic                     v1, s1_first, s1_last;
  logic [63:0]              s1_data;
  logic signed [COEF_W-1:0] s1_c0, s1_c1;
  logic                     v2, s2_first, s2_last;
  logic signed [PW-1:0]     s2_p [4];
  logic                     out_valid, out_user, out_last;
  logic [63:0]              out_data;

  function automatic logic signed [PW-1:0] mul(input logic signed [15:0]     x,
                                                input logic signed [COEF_W-1:0] c);
    return PW'(x) * PW'(c);
  endfunction

  function automatic logic [15:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW:0] r;
    r = $signed({p[PW-1], p}) + RND;
    r = r >>> SH;
    if (r > SAT_HI)      return 16'h7FFF;
    else if (r < SAT_LO) return 16'h8000;
    else                 return r[15:0];
  endfunction

  assign accept  = s_axis.tvalid && s_ready;
  assign restart = s_axis.tuser;
  assign fill_done = accept && !restart &&
                     ((state == FILL_FIRST && fill_cnt == BW'(BEATS - 1)) ||
                      (state == FILL_HALF  && fill_cnt == BW'(QTR - 1)));

  // Each stage moves forward only when the stage after it is empty or draining.
  assign adv3 = !out_valid || m_axis.tready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;
  assign issue      = (state == EMIT) && adv1;
  assign last_issue = issue && (rd_cnt == BW'(BEATS - 1));

  // NOTE: state/counters use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= FILL_FIRST;
    else         state <= state_nxt;
  end

  // NOTE: defaults first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      FILL_FIRST, FILL_HALF: begin
        if (accept && restart) state_nxt = FILL_FIRST;
        else if (fill_done)    state_nxt = EMIT;
      end
      EMIT:    if (last_issue) state_nxt = FILL_HALF;
      default: state_nxt = FILL_FIRST;
    endcase
  end

  // NOTE: sample and window RAMs carry no reset; their contents are always written before use.
  always_ff @(posedge clk) begin
    if (accept) sample_mem[restart ? '0 : wp] <= s_axis.tdata;
    if (coef_wr_en) begin
      if (coef_wr_addr[0]) coef_odd[coef_wr_addr[AW-1:1]]  <= coef_wr_data;
      else                 coef_even[coef_wr_addr[AW-1:1]] <= coef_wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp       <= '0;
      fill_cnt <= '0;
      rd_cnt   <= '0;
      s_ready  <= 1'b0;
    end else begin
      s_ready <= (state_nxt != EMIT);
      if (accept) begin
        if (restart) begin
          wp       <= BW'(1);
          fill_cnt <= BW'(1);
        end else begin
          wp       <= wp + 1'b1;
          fill_cnt <= fill_done ? '0 : fill_cnt + 1'b1;
        end
      end
      if (issue) rd_cnt <= last_issue ? '0 : rd_cnt + 1'b1;
    end
  end

  // Oldest beat sits at wp once a fill completes; wp is frozen during EMIT.
  always_ff @(posedge clk) begin
    if (adv1) begin
      s1_data <= sample_mem[wp + rd_cnt];
      s1_c0   <= coef_even[rd_cnt];
      s1_c1   <= coef_odd[rd_cnt];
    end
    if (adv2) begin
      s2_p[0] <= mul(s1_data[15:0],  s1_c0);
      s2_p[1] <= mul(s1_data[31:16], s1_c0);
      s2_p[2] <= mul(s1_data[47:32], s1_c1);
      s2_p[3] <= mul(s1_data[63:48], s1_c1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1        <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      v2        <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      seg_count <= '0;
    end else begin
      if (adv1) begin
        v1       <= issue;
        s1_first <= issue && (rd_cnt == '0);
        s1_last  <= last_issue;
      end
      if (adv2) begin
        v2       <= v1;
        s2_first <= s1_first;
        s2_last  <= s1_last;
      end
      if (adv3) begin
        out_valid <= v2;
        out_user  <= s2_first;
        out_last  <= s2_last;
        out_data  <= {round_sat(s2_p[3]), round_sat(s2_p[2]),
                      round_sat(s2_p[1]), round_sat(s2_p[0])};
      end
      if (out_valid && m_axis.tready && out_last) seg_count <= seg_count + 1'b1;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = 8'hFF;
  assign m_axis.tlast  = out_last;
  assign m_axis.tuser  = out_user;
  assign m_axis.tvalid = out_valid;
  assign busy = (state == EMIT) || v1 || v2 || out_valid;

endmodule

// File: tb/tb_welch_window_segmenter.sv
// Directed bench for welch_window_segmenter (SEG_LEN=8): a sample-level window model
// predicts every output beat, and one negedge process compares all accepted beats.
module tb_welch_window_segmenter;
  localparam int SEG_LEN = 8;
  localparam int COEF_W  = 16;
  localparam int BEATS   = SEG_LEN / 2;
  localparam int AW      = $clog2(SEG_LEN);

  typedef struct {
    logic [63:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              coef_wr_en = 1'b0;
  logic [AW-1:0]     coef_wr_addr = '0;
  logic [COEF_W-1:0] coef_wr_data = '0;
  logic [31:0]       seg_count;
  logic              busy;

  welch_window_segmenter_if s_axis();
  welch_window_segmenter_if m_axis();

  welch_window_segmenter #(.SEG_LEN(SEG_LEN), .COEF_W(COEF_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s_axis       (s_axis),
    .m_axis       (m_axis),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .seg_count    (seg_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_segs = 0;
  int rdy_mode = 0;  // 0: always ready, 1: toggle every cycle, 2: held low
  beat_t exp_q[$];
  logic [63:0] out_log[$];
  logic signed [15:0] smp_i [64];
  logic signed [15:0] smp_q [64];
  logic signed [15:0] cf [SEG_LEN];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // y = round(x*c / 2^15), saturated to 16 bits
  function automatic logic [15:0] win(input logic signed [15:0] x, input logic signed [15:0] c);
    int p, y;
    p = int'(x) * int'(c);
    y = (p + 16384) >>> 15;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    return y[15:0];
  endfunction

  // Every full segment of a capture of n samples starting at smp[first], hop SEG_LEN/2.
  task automatic expect_capture(input int first, input int n);
    for (int k = 0; k * (SEG_LEN / 2) + SEG_LEN <= n; k++) begin
      for (int b = 0; b < BEATS; b++) begin
        beat_t e;
        int n0;
        n0 = first + k * (SEG_LEN / 2) + 2 * b;
        e.data = {win(smp_q[n0+1], cf[2*b+1]), win(smp_i[n0+1], cf[2*b+1]),
                  win(smp_q[n0],   cf[2*b]),   win(smp_i[n0],   cf[2*b])};
        e.user = (b == 0);
        e.last = (b == BEATS - 1);
        exp_q.push_back(e);
      end
      exp_segs++;
    end
  endtask

  task automatic write_coef(input int j, input logic [15:0] v);
    @(negedge clk);
    coef_wr_en   = 1'b1;
    coef_wr_addr = AW'(j);
    coef_wr_data = v;
    cf[j]        = v;
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  task automatic send_beat(input int n, input logic user);
    int waited;
    waited = 0;
    @(negedge clk);
    s_axis.tdata  = {smp_q[n+1], smp_i[n+1], smp_q[n], smp_i[n]};
    s_axis.tuser  = user;
    s_axis.tvalid = 1'b1;
    while (!s_axis.tready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("send_timeout", 64'(s_axis.tready), 64'(1));
    else @(posedge clk);
  endtask

  task automatic play(input int first_beat, input int n_beats, input int tuser_beat);
    for (int b = first_beat; b < first_beat + n_beats; b++) send_beat(2 * b, b == tuser_beat);
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    s_axis.tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check({name, "_drain"}, 64'(exp_q.size()), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
  endtask

  // Output ready pattern, updated just after each rising edge.
  initial begin
    m_axis.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis.tready = 1'b1;
        1:       m_axis.tready = ~m_axis.tready;
        default: m_axis.tready = 1'b0;
      endcase
    end
  end

  // Compare process: every accepted output beat against the model, plus hold-while-stalled.
  logic        stalled = 1'b0;
  logic [63:0] held_data;
  logic        held_user, held_last;
  always @(negedge clk) begin
    if (!resetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(m_axis.tvalid), 64'(1));
        check("stall_data", m_axis.tdata, held_data);
        check("stall_flags", 64'({m_axis.tuser, m_axis.tlast}), 64'({held_user, held_last}));
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(m_axis.tvalid), 64'(0));
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", m_axis.tdata, e.data);
          check("out_tuser", 64'(m_axis.tuser), 64'(e.user));
          check("out_tlast", 64'(m_axis.tlast), 64'(e.last));
          out_log.push_back(m_axis.tdata);
        end
      end
      stalled   = m_axis.tvalid && !m_axis.tready;
      held_data = m_axis.tdata;
      held_user = m_axis.tuser;
      held_last = m_axis.tlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    s_axis.tdata  = '0;
    s_axis.tkeep  = 8'hFF;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tvalid = 1'b0;

    // Model pins against hand-computed values
    check("pin_win_1", 64'(win(16'sd1, 16'sh4000)), 64'(16'h0001));
    check("pin_win_3", 64'(win(16'sd3, 16'sh4000)), 64'(16'h0002));
    check("pin_win_sat", 64'(win(16'sh8000, 16'sh8000)), 64'(16'h7FFF));
    check("pin_win_max", 64'(win(16'sh7FFF, 16'sh7FFF)), 64'(16'h7FFE));

    // Reset state
    #12;
    check("rst_s_tready", 64'(s_axis.tready), 64'(0));
    check("rst_m_tvalid", 64'(m_axis.tvalid), 64'(0));
    check("rst_m_tdata", m_axis.tdata, 64'(0));
    check("rst_m_flags", 64'({m_axis.tuser, m_axis.tlast}), 64'(0));
    check("rst_m_tkeep", 64'(m_axis.tkeep), 64'(8'hFF));
    check("rst_seg_count", 64'(seg_count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    resetn = 1'b1;

    // T1: half-scale window, ramp input, full rate, three overlapped segments
    for (int j = 0; j < SEG_LEN; j++) write_coef(j, 16'h4000);
    for (int n = 0; n < 16; n++) begin
      smp_i[n] = 16'(n);
      smp_q[n] = 16'(-n);
    end
    rdy_mode = 0;
    out_log.delete();
    expect_capture(0, 16);
    for (int b = 0; b < BEATS; b++) send_beat(2 * b, b == 0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!m_axis.tvalid && lat < 20);
    s_axis.tvalid = 1'b0;
    s_axis.tuser  = 1'b0;
    check("t1_latency", 64'(lat), 64'(3));
    play(4, 4, -1);
    wait_drain("t1");
    check("t1_seg_count", 64'(seg_count), 64'(3));
    check("t1_beats", 64'(out_log.size()), 64'(12));
    check("t1_seg0_beat1", out_log[1], 64'hFFFF0002_FFFF0001);
    check("t1_seg1_beat0", out_log[4], 64'hFFFE0003_FFFE0002);

    // T2: saturation and near-full-scale rounding
    write_coef(0, 16'h8000);
    write_coef(1, 16'h7FFF);
    smp_i[0] = 16'sh8000; smp_q[0] = 16'sh7FFF;
    smp_i[1] = 16'sh7FFF; smp_q[1] = 16'sh8000;
    for (int n = 2; n < 8; n++) begin
      smp_i[n] = 16'(n * 1000);
      smp_q[n] = 16'(-n * 3000);
    end
    out_log.delete();
    expect_capture(0, 8);
    play(0, 4, 0);
    wait_drain("t2");
    check("t2_sat_beat", out_log[0], 64'h8001_7FFE_8001_7FFF);
    check("t2_seg_count", 64'(seg_count), 64'(exp_segs));

    // T3: T1 stream again with output ready toggling
    write_coef(0, 16'h4000);
    write_coef(1, 16'h4000);
    for (int n = 0; n < 16; n++) begin
      smp_i[n] = 16'(n);
      smp_q[n] = 16'(-n);
    end
    rdy_mode = 1;
    out_log.delete();
    expect_capture(0, 16);
    play(0, 8, 0);
    wait_drain("t3");
    rdy_mode = 0;
    check("t3_beats", 64'(out_log.size()), 64'(12));
    check("t3_seg0_beat1", out_log[1], 64'hFFFF0002_FFFF0001);
    check("t3_seg_count", 64'(seg_count), 64'(exp_segs));

    // T4: new capture (tuser) at sample 10 while filling the second half
    for (int n = 0; n < 18; n++) begin
      smp_i[n] = 16'(n * 100);
      smp_q[n] = 16'(n - 50);
    end
    out_log.delete();
    expect_capture(0, 10);
    expect_capture(10, 8);
    play(0, 5, 0);
    play(5, 4, 5);
    wait_drain("t4");
    check("t4_beats", 64'(out_log.size()), 64'(8));
    check("t4_restart_beat0", out_log[4], 64'hFFED0226_FFEC01F4);
    check("t4_seg_count", 64'(seg_count), 64'(exp_segs));

    // T5: ramp window, constant input
    for (int j = 0; j < SEG_LEN; j++) write_coef(j, 16'(j * 16'h0800));
    for (int n = 0; n < 8; n++) begin
      smp_i[n] = 16'sh1000;
      smp_q[n] = 16'sh0000;
    end
    out_log.delete();
    expect_capture(0, 8);
    play(0, 4, 0);
    wait_drain("t5");
    check("t5_beat3", out_log[3], 64'h0000_0700_0000_0600);
    check("t5_seg_count", 64'(seg_count), 64'(exp_segs));

    // T6: reset while a segment is stalled in EMIT, then a full refill
    for (int j = 0; j < SEG_LEN; j++) write_coef(j, 16'h4000);
    for (int n = 0; n < 8; n++) begin
      smp_i[n] = 16'(n * 7 - 20);
      smp_q[n] = 16'(300 - n * 50);
    end
    rdy_mode = 2;
    play(0, 4, 0);
    repeat (6) @(negedge clk);
    check("t6_stalled_valid", 64'(m_axis.tvalid), 64'(1));
    check("t6_stalled_busy", 64'(busy), 64'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_axis.tvalid), 64'(0));
    check("t6_rst_seg_count", 64'(seg_count), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_s_tready", 64'(s_axis.tready), 64'(0));
    exp_q.delete();
    exp_segs = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    rdy_mode = 0;
    out_log.delete();
    expect_capture(0, 8);
    play(0, 3, -1);
    repeat (6) @(negedge clk);
    check("t6_partial_no_out", 64'(m_axis.tvalid), 64'(0));
    check("t6_partial_ready", 64'(s_axis.tready), 64'(1));
    play(3, 1, -1);
    wait_drain("t6");
    check("t6_beats", 64'(out_log.size()), 64'(4));
    check("t6_seg_count", 64'(seg_count), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/welch_window_segmenter.md
Name: welch_window_segmenter

Overview:
- Sits directly downstream of welch_preprocess and ahead of the FFT.
- Takes the preprocessed complex sample stream and cuts it into segments of SEG_LEN samples with 50% overlap.
- Multiplies each sample by a runtime-loaded window coefficient and emits each windowed segment as one AXI-Stream packet.

Parameters:
SEG_LEN, 1024, samples per segment; power of two, 8..8192
COEF_W, 16, window coefficient width, signed Q1.15

Ports:
clk  in  1  stream clock
resetn  in  1  reset, asynchronous assert, active-low
s_axis_tdata  in  64  two complex samples; sample0 = [31:0], sample1 = [63:32]; each I = [15:0], Q = [31:16], signed
s_axis_tkeep  in  8  ignored; all-ones expected
s_axis_tlast  in  1  ignored for segmentation
s_axis_tuser  in  1  1 on first beat of a new capture, restarts segmentation
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
coef_wr_en  in  1  window RAM write strobe
coef_wr_addr  in  log2(SEG_LEN)  coefficient index
coef_wr_data  in  COEF_W  coefficient value
m_axis_tdata  out  64  two windowed samples, same packing as input
m_axis_tkeep  out  8  constant 8'hFF
m_axis_tlast  out  1  last beat of segment
m_axis_tuser  out  1  first beat of segment
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
seg_count  out  32  segments emitted since reset, wraps
busy  out  1  state is EMIT or output pipeline non-empty

Behaviour:
- Reset values: s_axis_tready=0, all m_axis_* = 0 except tkeep=8'hFF, seg_count=0, busy=0, state FILL_FIRST, fill and read pointers 0.
- Coefficient RAM contents are not reset. Writes take effect on the next cycle; writing during EMIT is allowed but results are undefined for that segment.
- Sample buffer: circular, SEG_LEN samples, stored as SEG_LEN/2 beats. Write pointer wp is in beats.
- States:
  - FILL_FIRST: tready=1. Accept beats until SEG_LEN/2 beats are stored, then go to EMIT.
  - FILL_HALF: tready=1. Accept SEG_LEN/4 new beats, then go to EMIT.
  - EMIT: tready=0. Read SEG_LEN/2 beats starting at the oldest beat (wp after fill, modulo SEG_LEN/2). When the last read issues, go to FILL_HALF.
- tuser=1 on an accepted beat in any FILL state: discard history, store that beat as beat 0, state becomes FILL_FIRST. tuser is not sampled in EMIT.
- Segment k (k from 0) covers input samples k*SEG_LEN/2 .. k*SEG_LEN/2+SEG_LEN-1.
- Arithmetic, per I and Q independently:
  - p = sample * coef[j], 32-bit signed, where j is the sample index within the segment (beat b gives j = 2b and 2b+1).
  - y = (p + 2^14) >>> 15, saturated to [-32768, 32767].
- Pipeline: RAM read (1 cycle), multiply register (1), round/saturate output register (1). First output valid 3 cycles after entering EMIT, when tready is held high.
  - Reads advance only while the pipeline can accept data, so there is no loss under backpressure.
  - m_axis_* stay stable while tvalid=1 and tready=0.
  - Full-rate output of 1 beat/cycle when tready=1.
- tuser=1 on beat 0 of a segment; tlast=1 on beat SEG_LEN/2-1. seg_count increments on the accepted tlast beat.
- State returns to FILL_HALF once the last read issues; the pipeline drains concurrently, and input may restart before the last output beat.

Test Plan:
- SEG_LEN=8, all coefs 0x4000, input I=n, Q=-n for samples n=0..15, tuser on beat 0 -> 3 segments (samples 0-7, 4-11, 8-15). Outputs I=(n*16384+16384)>>15, e.g. n=1→1, n=2→1, n=3→2; Q symmetric. tuser/tlast on beats 0/3; seg_count=3.
- Coefs 0x8000, sample I=0x8000 -> output I=0x7FFF (saturation). Sample I=0x7FFF with coef 0x7FFF -> 0x7FFE.
- m_axis_tready toggling 1010... during EMIT -> data identical to the full-rate run, no duplicates or drops, tdata stable while stalled.
- tuser reasserted mid-FILL_HALF at sample 10 -> history discarded; next segment is samples 10..17 with tuser on its beat 0.
- resetn asserted mid-EMIT -> tvalid drops immediately, seg_count=0. After release, the first segment needs a full SEG_LEN fill.
- Write coef[j]=j*0x0800, input all I=0x1000 -> output I[j]=(0x1000*j*0x800+0x4000)>>15 = j*0x100.
